dualport_ram_sclr: RTL
======================

# dualport_ram_sclr

Single-clock, parametrised true dual-port RAM with two independent read/write ports, per-segment write enables and a sequential hardware clear engine. It is the successor to the plain dual-port RAM used for predictor and tag tables. It replaces the combinational clear with a deterministic DEPTH-cycle sweep and defines every same-cycle port collision. It sits beside the pipeline's prediction/tag structures, which use the clear on flush or context switch.

## Interface
- ADDRLEN, 10, address width of both ports
- DATALEN, 32, data width of both ports
- DEPTH, 1024, number of entries; must satisfy DEPTH <= 2**ADDRLEN and DEPTH >= 2
- SEGLEN, 8, write-enable granularity; DATALEN must be a multiple of SEGLEN; NSEG = DATALEN/SEGLEN
- clk  in  1  single clock, all state updates on posedge
- reset_x  in  1  asynchronous, active-low reset
- addra  in  ADDRLEN  port A address
- wdataa  in  DATALEN  port A write data
- wea  in  NSEG  port A segment write enables; bit i covers bits [i*SEGLEN +: SEGLEN]
- rdataa  out  DATALEN  port A registered read data
- addrb  in  ADDRLEN  port B address
- wdatab  in  DATALEN  port B write data
- web  in  NSEG  port B segment write enables
- rdatab  out  DATALEN  port B registered read data
- clear_req  in  1  request to zero the whole array
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after the last entry is zeroed

## Operation
- Reset (reset_x low, asynchronous): rdataa=0, rdatab=0, clear_busy=0, clear_done=0, FSM=IDLE, sweep counter=0. Array contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1 at a posedge. The counter loads 0.
  - CLEAR: each posedge writes 0 to mem[counter], then increments the counter.
  - CLEAR -> IDLE on the posedge that writes entry DEPTH-1. clear_done=1 for the following cycle only.
- clear_req in CLEAR is ignored; there is no restart and no queueing. clear_req coinciding with the done pulse starts a new sweep.
- Port reads: rdataX <= mem[addrX] every posedge in IDLE. Addresses >= DEPTH return 0 and never write.
- Port writes in IDLE: each segment i with weX[i]=1 writes wdataX segment i into mem[addrX]. Unselected segments are unchanged.
- In CLEAR: wea/web are ignored, and rdataa/rdatab load 0 each cycle.
- Write/write collision (addra==addrb, both enabling segment i): port B data wins for that segment. Non-overlapping segments from both ports are merged.
- Read/write on the same port: read-old. rdataX returns the pre-write contents.
- Cross-port read/write (one port reads X while the other writes X): governed by the configuration macro.
- Reset asserted mid-sweep: the FSM returns to IDLE with no done pulse. Entries not yet swept keep their old values.

## Timing
- Read latency: 1 cycle. The address is presented before edge N, and data is valid after edge N.
- Write takes effect at edge N and is visible to a read addressed after edge N.
- Clear: clear_req sampled at edge E0 gives clear_busy=1 after E0. Edges E1..E_DEPTH zero addresses 0..DEPTH-1. After E_DEPTH, clear_busy=0 and clear_done=1 for exactly one cycle. Total busy time is DEPTH cycles.
- The first normal access is accepted at edge E_DEPTH+1.

## Configuration
- RAM_BYPASS_EN defined: cross-port write-first forwarding. When port B writes address X at edge N and port A reads X at edge N, rdataa shows the merged new data (per segment), and symmetrically for B reading A's write. If both ports write X while either reads X, the forwarded value follows the B-wins merge.
- RAM_BYPASS_EN undefined: cross-port reads return the old contents (read-old).
- Same-port behaviour and clear behaviour are identical in both builds.

## Test plan
- Reset then basic access: write 0xDEADBEEF at A:5 with wea=4'hF, then read A:5 → rdataa=0xDEADBEEF one cycle later; rdatab=0 during reset.
- Segment enables: mem[7]=0x11223344, then port B writes 0xAABBCCDD with web=4'b0101 → mem[7]=0x11BB33DD.
- Write collision: A writes 0x0000FFFF and B writes 0xFFFF0000 to addr 3 with all segments enabled → mem[3]=0xFFFF0000. With wea=4'b0011 and web=4'b1100 → mem[3]=0xFFFFFFFF.
- Cross-port read: mem[9]=1; B writes 2 to 9 while A reads 9 → rdataa=2 with RAM_BYPASS_EN defined, rdataa=1 without it.
- Clear sweep (DEPTH=16): fill all entries with 0xFF, pulse clear_req → clear_busy high for 16 cycles, writes during busy ignored, clear_done high for one cycle, all reads then return 0.
- Reset mid-clear (DEPTH=16): assert reset_x low after 6 sweep cycles → busy=0 with no done pulse; entries 0..5 read 0 and entries 6..15 keep 0xFF.

Source files
------------

// File: rtl/dualport_ram_sclr.sv
// dualport_ram_sclr: single-clock true dual-port RAM with per-segment write
// enables, fully defined same-cycle collisions and a DEPTH-cycle clear sweep.
//
// Optional feature macro: RAM_BYPASS_EN
//   defined   -> a read on one port returns the merged new data when the
//                other port writes the same address in the same cycle.
//   undefined -> cross-port reads return the old contents.
//
// Ports:
//   clk                       single clock, all updates on posedge
//   reset_x                   asynchronous active-low reset
//   addra/wdataa/wea/rdataa   port A address, write data, segment enables, read data
//   addrb/wdatab/web/rdatab   port B address, write data, segment enables, read data
//   clear_req                 request to zero the whole array
//   clear_busy                clear sweep in progress
//   clear_done                one-cycle pulse after the last entry is zeroed
module dualport_ram_sclr #(
  parameter int unsigned ADDRLEN = 10,
  parameter int unsigned DATALEN = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned SEGLEN  = 8
) (
  input  logic                        clk,
  input  logic                        reset_x,
  input  logic [ADDRLEN-1:0]          addra,
  input  logic [DATALEN-1:0]          wdataa,
  input  logic [DATALEN/SEGLEN-1:0]   wea,
  output logic [DATALEN-1:0]          rdataa,
  input  logic [ADDRLEN-1:0]          addrb,
  input  logic [DATALEN-1:0]          wdatab,
  input  logic [DATALEN/SEGLEN-1:0]   web,
  output logic [DATALEN-1:0]          rdatab,
  input  logic                        clear_req,
  output logic                        clear_busy,
  output logic                        clear_done
);

  localparam int unsigned NSEG = DATALEN / SEGLEN;
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic                busy_d, done_d;

  logic [DATALEN-1:0]  mem [DEPTH];

  logic                a_ok, b_ok;
  logic                a_wr, b_wr;
  logic                same_addr;
  logic [IDXW-1:0]     idx_a, idx_b;
  logic [DATALEN-1:0]  word_a, word_b;
  logic [DATALEN-1:0]  rdataa_d, rdatab_d;

  // Address decode: out-of-range addresses neither read nor write.
  assign a_ok      = (32'(addra) < DEPTH);
  assign b_ok      = (32'(addrb) < DEPTH);
  assign idx_a     = IDXW'(addra);
  assign idx_b     = IDXW'(addrb);
  assign same_addr = (addra == addrb);
  assign a_wr      = (state_q == IDLE) && a_ok && (|wea);
  assign b_wr      = (state_q == IDLE) && b_ok && (|web);

  // New word at each port's address after both ports' segments are applied;
  // port B is applied last so it wins overlapping segments.
  always_comb begin
    word_a = mem[idx_a];
    word_b = mem[idx_b];
    for (int i = 0; i < int'(NSEG); i++) begin
      if (wea[i])
        word_a[i*SEGLEN +: SEGLEN] = wdataa[i*SEGLEN +: SEGLEN];
      if (web[i] && same_addr)
        word_a[i*SEGLEN +: SEGLEN] = wdatab[i*SEGLEN +: SEGLEN];
      if (wea[i] && same_addr)
        word_b[i*SEGLEN +: SEGLEN] = wdataa[i*SEGLEN +: SEGLEN];
      if (web[i])
        word_b[i*SEGLEN +: SEGLEN] = wdatab[i*SEGLEN +: SEGLEN];
    end
  end

  // Read data: same-port read-old; cross-port forwarding only with BYPASS.
  always_comb begin
    rdataa_d = '0;
    rdatab_d = '0;
    if (state_q == IDLE) begin
      if (a_ok)
        rdataa_d = (BYPASS && b_wr && same_addr) ? word_a : mem[idx_a];
      if (b_ok)
        rdatab_d = (BYPASS && a_wr && same_addr) ? word_b : mem[idx_b];
    end
  end

  // Clear FSM next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == IDXW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      rdataa     <= '0;
      rdatab     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
      rdataa     <= rdataa_d;
      rdatab     <= rdatab_d;
    end
  end

  // Storage array (not reset); the sweep owns the write path while clearing.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (a_wr) mem[idx_a] <= word_a;
      if (b_wr) mem[idx_b] <= word_b;
    end
  end

endmodule
